// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: CPU-side byte FIFO draining into an 8N1 serializer (8E1 when UART_TX_PARITY_EN is defined).
// Latency: byte pushed at edge k into an empty, idle block is popped at k+1 and its start bit drives o_uart_tx from k+2.
// Backpressure: o_ready is low while the FIFO holds 2**DEPTH_LOG2 bytes; a push offered then is dropped.
module uart_tx_fifo #(
    parameter int CLK_FREQ_HZ = 160000000,
    parameter int BAUD_RATE   = 1000000,
    parameter int DEPTH_LOG2  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            i_data,
    input  logic                  i_valid,
    output logic                  o_ready,
    output logic                  o_busy,
    output logic [DEPTH_LOG2:0]   o_level,
    output logic                  o_uart_tx
);

    // Clock cycles per serial bit; the baud counter only needs to hold DIV-1.
    localparam int DIV   = CLK_FREQ_HZ / BAUD_RATE;
    localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int LVL_W = DEPTH_LOG2 + 1;

    localparam logic [CNT_W-1:0] DIV_M1   = CNT_W'(DIV - 1);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;
`endif

    // FIFO state
    logic [7:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]      level_q, level_d;
    logic                  push;
    logic                  pop;
    logic [7:0]            head_dat;

    // Serializer state
    state_t                state_q, state_d;
    logic [CNT_W-1:0]      baud_q, baud_d;
    logic [2:0]            bit_q, bit_d;
    logic [7:0]            shift_q, shift_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  bit_end;
`ifdef UART_TX_PARITY_EN
    logic                  parity_q, parity_d;
`endif

    // Full is decoded from the registered level only, so a same-cycle pop never makes room for a push.
    assign o_ready  = (level_q != FULL_LVL);
    assign push     = i_valid && o_ready;
    assign head_dat = mem_q[rd_ptr_q];
    assign bit_end  = (baud_q == '0);

    // FIFO pointer and occupancy update; simultaneous push and pop leave the level unchanged.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
        end
        if (push && !pop) begin
            level_d = level_q + LVL_W'(1);
        end else if (!push && pop) begin
            level_d = level_q - LVL_W'(1);
        end
    end

    // Storage is not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= i_data;
        end
    end

    // Serializer next-state logic; the line level is a registered copy of the current state's bit.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = 1'b1;
        pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif

        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (level_q != '0) begin
                    pop     = 1'b1;
                    baud_d  = DIV_M1;
                    bit_d   = 3'd0;
                    state_d = S_START;
                end
            end

            S_START: begin
                tx_d = 1'b0;
                if (bit_end) begin
                    baud_d  = DIV_M1;
                    bit_d   = 3'd0;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q - CNT_W'(1);
                end
            end

            S_DATA: begin
                tx_d = shift_q[0];
                if (bit_end) begin
                    baud_d  = DIV_M1;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q - CNT_W'(1);
                end
            end

`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                tx_d = parity_q;
                if (bit_end) begin
                    baud_d  = DIV_M1;
                    state_d = S_STOP;
                end else begin
                    baud_d = baud_q - CNT_W'(1);
                end
            end
`endif

            S_STOP: begin
                tx_d = 1'b1;
                if (bit_end) begin
                    // Chain straight into the next start bit when more data is waiting.
                    if (level_q != '0) begin
                        pop     = 1'b1;
                        baud_d  = DIV_M1;
                        bit_d   = 3'd0;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    baud_d = baud_q - CNT_W'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Every pop loads the head byte into the shifter.
        if (pop) begin
            shift_d = head_dat;
`ifdef UART_TX_PARITY_EN
            parity_d = ^head_dat;
`endif
        end
    end

    // Busy tracks the line: it is registered alongside tx so it stays high through the final stop bit.
    always_comb begin
        busy_d = (level_q != '0) || (state_q != S_IDLE);
    end

    // State registers with synchronous reset; reset flushes the FIFO and idles the line.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign o_level   = level_q;
    assign o_busy    = busy_q;
    assign o_uart_tx = tx_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: scoreboard bench; a line monitor decodes frames from o_uart_tx and compares against queued bytes.
// Latency: checks start-bit timing relative to the push edge and start-to-start spacing of chained frames.
// Backpressure: fills the FIFO past capacity and expects exactly the accepted bytes on the line.
`timescale 1ns/1ps
module tb_uart_tx_fifo;

    localparam int CLK_HZ = 16000000;
    localparam int BAUD   = 1000000;
    localparam int DL2    = 4;
    localparam int DIV    = CLK_HZ / BAUD;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME = DIV * NB;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [7:0]   i_data = 8'h00;
    logic         i_valid = 1'b0;
    logic         o_ready;
    logic         o_busy;
    logic [DL2:0] o_level;
    logic         o_uart_tx;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    logic [7:0] sb[$];
    int         starts[$];
    bit         mon_en = 1'b1;
    bit         mon_busy = 1'b0;

    uart_tx_fifo #(
        .CLK_FREQ_HZ (CLK_HZ),
        .BAUD_RATE   (BAUD),
        .DEPTH_LOG2  (DL2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .i_data    (i_data),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .o_busy    (o_busy),
        .o_level   (o_level),
        .o_uart_tx (o_uart_tx)
    );

    always #5 clk = ~clk;

    // Count of rising edges; read on falling edges only.
    always @(posedge clk) cyc <= cyc + 1;

    // Line monitor: detects a start bit, samples each bit mid-cell, compares against the scoreboard.
    initial begin : monitor
        logic [7:0] got;
        logic [7:0] exp_b;
        logic       start_b;
        logic       stop_b;
`ifdef UART_TX_PARITY_EN
        logic       par_b;
`endif
        forever begin
            @(negedge clk);
            if (mon_en && (reset === 1'b0) && (o_uart_tx === 1'b0)) begin
                mon_busy = 1'b1;
                starts.push_back(cyc);
                got = 8'h00;
                repeat (DIV / 2) @(negedge clk);
                start_b = o_uart_tx;
                for (int j = 0; j < 8; j++) begin
                    repeat (DIV) @(negedge clk);
                    got[j] = o_uart_tx;
                end
`ifdef UART_TX_PARITY_EN
                repeat (DIV) @(negedge clk);
                par_b = o_uart_tx;
`endif
                repeat (DIV) @(negedge clk);
                stop_b = o_uart_tx;
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL frame_unexpected: decoded 0x%02h, required no frame", got);
                end else begin
                    exp_b = sb.pop_front();
                    if (got !== exp_b) begin
                        miscompares++;
                        $display("FAIL frame_data: decoded 0x%02h, required 0x%02h", got, exp_b);
                    end
                    vectors++;
                    if ({start_b, stop_b} !== 2'b01) begin
                        miscompares++;
                        $display("FAIL frame_bits: start=%b stop=%b, required start=0 stop=1", start_b, stop_b);
                    end
`ifdef UART_TX_PARITY_EN
                    vectors++;
                    if (par_b !== (^exp_b)) begin
                        miscompares++;
                        $display("FAIL frame_parity: byte 0x%02h parity=%b, required %b", exp_b, par_b, ^exp_b);
                    end
`endif
                end
                // Leave the loop one cycle before the next possible start cell.
                repeat (DIV / 2 - 1) @(negedge clk);
                mon_busy = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Single push; returns at the falling edge right after the push edge (cyc == edge_no).
    task automatic push_one(input logic [7:0] b, output int edge_no);
        @(negedge clk);
        i_data  = b;
        i_valid = 1'b1;
        edge_no = cyc + 1;
        @(negedge clk);
        i_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget, input string tag);
        int n;
        n = 0;
        while ((sb.size() != 0 || mon_busy || o_busy !== 1'b0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (n >= budget) begin
            miscompares++;
            $display("FAIL %s_drain: timed out after %0d cycles with %0d bytes pending, required all frames sent", tag, n, sb.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if (o_uart_tx !== 1'b1) begin miscompares++; $display("FAIL reset_tx: got %b, required 1", o_uart_tx); end
        vectors++;
        if (o_level !== '0) begin miscompares++; $display("FAIL reset_level: got %0d, required 0", o_level); end
        vectors++;
        if (o_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b, required 1", o_ready); end
        vectors++;
        if (o_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b, required 0", o_busy); end
    endtask

    task automatic test_single();
        int k;
        starts.delete();
        sb.push_back(8'h55);
        push_one(8'h55, k);
        vectors++;
        if (o_level !== 5'd1) begin miscompares++; $display("FAIL single_level: got %0d, required 1", o_level); end
        wait_cyc(k + 1);
        vectors++;
        if (o_uart_tx !== 1'b1) begin miscompares++; $display("FAIL single_tx_k1: got %b, required 1", o_uart_tx); end
        vectors++;
        if (o_busy !== 1'b1) begin miscompares++; $display("FAIL single_busy_rise: got %b, required 1", o_busy); end
        wait_cyc(k + 2);
        vectors++;
        if (o_uart_tx !== 1'b0) begin miscompares++; $display("FAIL single_tx_k2: got %b, required 0", o_uart_tx); end
        wait_cyc(k + 1 + FRAME);
        vectors++;
        if (o_busy !== 1'b1 || o_uart_tx !== 1'b1) begin
            miscompares++;
            $display("FAIL single_last_stop: busy=%b tx=%b, required busy=1 tx=1", o_busy, o_uart_tx);
        end
        wait_cyc(k + 2 + FRAME);
        vectors++;
        if (o_busy !== 1'b0) begin miscompares++; $display("FAIL single_busy_fall: got %b, required 0", o_busy); end
        wait_drain(4 * FRAME, "single");
        vectors++;
        if (starts.size() < 1) begin
            miscompares++;
            $display("FAIL single_start: got no start bit, required start at push edge + 2");
        end else if (starts[0] - k != 2) begin
            miscompares++;
            $display("FAIL single_start: start at push edge + %0d, required + 2", starts[0] - k);
        end
    endtask

    task automatic test_back_to_back();
        logic [DL2:0] exp_lvl [3];
        int peak;
        exp_lvl[0] = 5'd1;
        exp_lvl[1] = 5'd1;
        exp_lvl[2] = 5'd2;
        peak = 0;
        starts.delete();
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            i_data  = 8'h41 + 8'(i);
            i_valid = 1'b1;
            sb.push_back(8'h41 + 8'(i));
            @(negedge clk);
            if (int'(o_level) > peak) peak = int'(o_level);
            vectors++;
            if (o_level !== exp_lvl[i]) begin
                miscompares++;
                $display("FAIL b2b_level_%0d: got %0d, required %0d", i, o_level, exp_lvl[i]);
            end
        end
        i_valid = 1'b0;
        vectors++;
        if (peak != 2) begin miscompares++; $display("FAIL b2b_peak: got %0d, required 2", peak); end
        wait_drain(4 * FRAME, "b2b");
        vectors++;
        if (starts.size() != 3) begin
            miscompares++;
            $display("FAIL b2b_frames: got %0d frames, required 3", starts.size());
        end else begin
            for (int i = 1; i < 3; i++) begin
                vectors++;
                if (starts[i] - starts[i-1] != FRAME) begin
                    miscompares++;
                    $display("FAIL b2b_gap_%0d: start spacing %0d, required %0d", i, starts[i] - starts[i-1], FRAME);
                end
            end
        end
    endtask

    task automatic test_overflow();
        int k;
        sb.push_back(8'hFF);
        push_one(8'hFF, k);
        @(negedge clk);
        // 0xFF is now in the shifter; nothing pops again for a whole frame.
        for (int i = 0; i < 17; i++) begin
            vectors++;
            if (o_ready !== (i < 16)) begin
                miscompares++;
                $display("FAIL ovf_ready_%0d: got %b, required %b", i, o_ready, (i < 16));
            end
            vectors++;
            if (int'(o_level) != i) begin
                miscompares++;
                $display("FAIL ovf_level_%0d: got %0d, required %0d", i, o_level, i);
            end
            i_data  = 8'(i);
            i_valid = 1'b1;
            if (i < 16) sb.push_back(8'(i));
            @(negedge clk);
        end
        i_valid = 1'b0;
        vectors++;
        if (o_level !== 5'd16 || o_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_full: level=%0d ready=%b, required level=16 ready=0", o_level, o_ready);
        end
        wait_drain(18 * FRAME + 100, "ovf");
    endtask

    task automatic test_reset_mid();
        int k;
        int k2;
        mon_en = 1'b0;
        push_one(8'hA5, k);
        push_one(8'h99, k2);
        // Bit 3 of 0xA5 (a zero) occupies cells k+2+4*DIV .. k+2+5*DIV-1.
        wait_cyc(k + 2 + 4 * DIV + 5);
        vectors++;
        if (o_uart_tx !== 1'b0 || o_level !== 5'd1) begin
            miscompares++;
            $display("FAIL rst_mid_pre: tx=%b level=%0d, required tx=0 level=1", o_uart_tx, o_level);
        end
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if (o_uart_tx !== 1'b1) begin miscompares++; $display("FAIL rst_mid_tx: got %b, required 1", o_uart_tx); end
        vectors++;
        if (o_level !== '0) begin miscompares++; $display("FAIL rst_mid_level: got %0d, required 0", o_level); end
        vectors++;
        if (o_ready !== 1'b1 || o_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid_flags: ready=%b busy=%b, required ready=1 busy=0", o_ready, o_busy);
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (o_uart_tx !== 1'b1 || o_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid_idle: tx=%b busy=%b, required tx=1 busy=0", o_uart_tx, o_busy);
        end
        mon_en = 1'b1;
        sb.push_back(8'h3C);
        push_one(8'h3C, k);
        wait_drain(3 * FRAME, "rst_mid");
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        starts.delete();
        @(negedge clk);
        i_data  = 8'h07;
        i_valid = 1'b1;
        sb.push_back(8'h07);
        @(negedge clk);
        i_data  = 8'h03;
        sb.push_back(8'h03);
        @(negedge clk);
        i_valid = 1'b0;
        wait_drain(3 * FRAME, "parity");
        vectors++;
        if (starts.size() != 2) begin
            miscompares++;
            $display("FAIL parity_frames: got %0d frames, required 2", starts.size());
        end else if (starts[1] - starts[0] != 11 * DIV) begin
            miscompares++;
            $display("FAIL parity_frame_len: got %0d cycles, required %0d", starts[1] - starts[0], 11 * DIV);
        end
    endtask
`endif

    initial begin : main
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_reset_mid();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
